// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of a five-stage MIPS pipeline, sitting between execute
// and writeback. One instruction is accepted at a time. Loads and stores are
// issued on a simple data bus: a request is raised and held until the bus
// reports data_ok.
//
// Handshake (execute -> mem): an instruction transfers on a rising edge where
// ex_valid & mem_ready are both high. mem_ready depends only on stage state
// and reset, never on ex_valid. Bus side: dreq_valid stays high with
// addr/strobe/data frozen until dresp_data_ok is seen high at a rising edge;
// that edge completes the request. Writeback never stalls, so wb_* is a plain
// register and wb_valid is a one-cycle pulse per retired instruction.
//
// Ports
//   clk, reset           clock; synchronous active-low reset
//   ex_valid/mem_ready   execute -> mem handshake
//   ex_*                 instruction fields from execute
//   dreq_*               data bus request (valid, addr, strobe, data)
//   dresp_data_ok/data   data bus completion and raw load word
//   wb_*                 registered bundle for writeback, incl. wb_misalign
//   dbg_state            current FSM state (0 = IDLE, 1 = BUSY)
// ---------------------------------------------------------------------------
module mem_stage (
  input  logic        clk,
  input  logic        reset,

  input  logic        ex_valid,
  output logic        mem_ready,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_mem_unsigned,
  input  logic        ex_mem_to_reg,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_regfile_wa,

  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,

  output logic        wb_valid,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_read_data,
  output logic        wb_mem_to_reg,
  output logic        wb_reg_write,
  output logic [4:0]  wb_regfile_wa,
  output logic        wb_misalign,

  output logic [0:0]  dbg_state
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  state_t state_q;
  state_t state_d;

  // Fields latched at acceptance of a memory op, used while BUSY.
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        store_q;
  logic        mem_to_reg_q;
  logic        reg_write_q;
  logic [4:0]  wa_q;

  // Request-side registers.
  logic [31:0] dreq_addr_q;
  logic [3:0]  dreq_strobe_q;
  logic [31:0] dreq_data_q;

  // Writeback registers.
  logic        wb_valid_q;
  logic [31:0] wb_alu_result_q;
  logic [31:0] wb_read_data_q;
  logic        wb_mem_to_reg_q;
  logic        wb_reg_write_q;
  logic [4:0]  wb_regfile_wa_q;
  logic        wb_misalign_q;

  // Decode of the incoming instruction.
  logic        in_is_mem;
  logic        in_is_store;
  logic        in_misalign;
  logic        accept;
  logic [3:0]  in_strobe;
  logic [31:0] in_lane_data;

  // FSM control strobes.
  logic        capture;
  logic        retire_direct;
  logic        retire_mem;

  // Load extraction.
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  // ---------------------------------------------------------------------
  // Input decode
  // ---------------------------------------------------------------------
  assign mem_ready   = reset & (state_q == IDLE);
  assign accept      = ex_valid & mem_ready;
  assign in_is_mem   = ex_mem_read | ex_mem_write;
  // When both read and write are set the op is a store.
  assign in_is_store = ex_mem_write;

  // Size 11 is treated like a word, so size[1] alone selects word checks.
  always_comb begin
    in_misalign = 1'b0;
    if (in_is_mem) begin
      if (ex_mem_size == SIZE_HALF) begin
        in_misalign = ex_alu_result[0];
      end else if (ex_mem_size[1]) begin
        in_misalign = (ex_alu_result[1:0] != 2'b00);
      end
    end
  end

  // Store lane placement. The data is replicated across lanes so the
  // strobe alone picks which bytes memory takes.
  always_comb begin
    in_strobe    = 4'b0000;
    in_lane_data = ex_store_data;
    if (ex_mem_size == SIZE_BYTE) begin
      in_lane_data = {4{ex_store_data[7:0]}};
      in_strobe    = 4'b0001 << ex_alu_result[1:0];
    end else if (ex_mem_size == SIZE_HALF) begin
      in_lane_data = {2{ex_store_data[15:0]}};
      in_strobe    = 4'b0011 << ex_alu_result[1:0];
    end else begin
      in_lane_data = ex_store_data;
      in_strobe    = 4'b1111;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    capture       = 1'b0;
    retire_direct = 1'b0;
    retire_mem    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_is_mem && !in_misalign) begin
            capture = 1'b1;
            state_d = BUSY;
          end else begin
            // Non-memory and misaligned ops retire on the next edge
            // without touching the bus.
            retire_direct = 1'b1;
          end
        end
      end
      BUSY: begin
        if (dresp_data_ok) begin
          retire_mem = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Load extraction from the raw bus word, using the latched offset.
  // ---------------------------------------------------------------------
  always_comb begin
    load_byte = dresp_data[7:0];
    case (addr_q[1:0])
      2'b00: load_byte = dresp_data[7:0];
      2'b01: load_byte = dresp_data[15:8];
      2'b10: load_byte = dresp_data[23:16];
      2'b11: load_byte = dresp_data[31:24];
      default: load_byte = dresp_data[7:0];
    endcase
  end

  assign load_half = addr_q[1] ? dresp_data[31:16] : dresp_data[15:0];

  always_comb begin
    load_ext = dresp_data;
    if (size_q == SIZE_BYTE) begin
      load_ext = unsigned_q ? {24'h000000, load_byte}
                            : {{24{load_byte[7]}}, load_byte};
    end else if (size_q == SIZE_HALF) begin
      load_ext = unsigned_q ? {16'h0000, load_half}
                            : {{16{load_half[15]}}, load_half};
    end
  end

  // ---------------------------------------------------------------------
  // Latched instruction and bus request registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q        <= 32'h0;
      size_q        <= 2'b00;
      unsigned_q    <= 1'b0;
      store_q       <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      reg_write_q   <= 1'b0;
      wa_q          <= 5'd0;
      dreq_addr_q   <= 32'h0;
      dreq_strobe_q <= 4'b0000;
      dreq_data_q   <= 32'h0;
    end else if (capture) begin
      addr_q        <= ex_alu_result;
      size_q        <= ex_mem_size;
      unsigned_q    <= ex_mem_unsigned;
      store_q       <= in_is_store;
      mem_to_reg_q  <= ex_mem_to_reg;
      reg_write_q   <= ex_reg_write;
      wa_q          <= ex_regfile_wa;
      dreq_addr_q   <= ex_alu_result;
      dreq_strobe_q <= in_is_store ? in_strobe : 4'b0000;
      dreq_data_q   <= in_lane_data;
    end
  end

  // Request fields only change on capture, which happens only in IDLE, so
  // they are stable for the whole time dreq_valid is high.
  assign dreq_valid  = (state_q == BUSY);
  assign dreq_addr   = dreq_addr_q;
  assign dreq_strobe = dreq_strobe_q;
  assign dreq_data   = dreq_data_q;

  // ---------------------------------------------------------------------
  // Writeback register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_valid_q      <= 1'b0;
      wb_misalign_q   <= 1'b0;
      wb_alu_result_q <= 32'h0;
      wb_read_data_q  <= 32'h0;
      wb_mem_to_reg_q <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_regfile_wa_q <= 5'd0;
    end else begin
      wb_valid_q    <= retire_direct | retire_mem;
      wb_misalign_q <= retire_direct & in_misalign;
      if (retire_direct) begin
        wb_alu_result_q <= ex_alu_result;
        wb_read_data_q  <= 32'h0;
        wb_mem_to_reg_q <= ex_mem_to_reg;
        // A misaligned access must not update the register file.
        wb_reg_write_q  <= ex_reg_write & ~in_misalign;
        wb_regfile_wa_q <= ex_regfile_wa;
      end else if (retire_mem) begin
        wb_alu_result_q <= addr_q;
        wb_read_data_q  <= store_q ? 32'h0 : load_ext;
        wb_mem_to_reg_q <= mem_to_reg_q;
        wb_reg_write_q  <= reg_write_q;
        wb_regfile_wa_q <= wa_q;
      end
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_misalign   = wb_misalign_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_read_data  = wb_read_data_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_regfile_wa = wb_regfile_wa_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage: directed, table-driven bench for mem_stage. Inputs change
// just after the falling edge; outputs are checked just before the next
// falling edge, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        ex_valid = 1'b0;
  logic        mem_ready;
  logic [31:0] ex_alu_result = 32'h0;
  logic [31:0] ex_store_data = 32'h0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [1:0]  ex_mem_size = 2'b00;
  logic        ex_mem_unsigned = 1'b0;
  logic        ex_mem_to_reg = 1'b0;
  logic        ex_reg_write = 1'b0;
  logic [4:0]  ex_regfile_wa = 5'd0;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_data_ok = 1'b0;
  logic [31:0] dresp_data = 32'h0;
  logic        wb_valid;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_read_data;
  logic        wb_mem_to_reg;
  logic        wb_reg_write;
  logic [4:0]  wb_regfile_wa;
  logic        wb_misalign;
  logic [0:0]  dbg_state;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .mem_ready(mem_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .ex_regfile_wa(ex_regfile_wa),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .wb_valid(wb_valid), .wb_alu_result(wb_alu_result),
    .wb_read_data(wb_read_data), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_reg_write(wb_reg_write), .wb_regfile_wa(wb_regfile_wa),
    .wb_misalign(wb_misalign), .dbg_state(dbg_state)
  );

  // -------------------------------------------------------------------------
  // Scoreboard counters and compare helper
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Vector table
  // -------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] sd;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic        m2r;
    logic        rw;
    logic [4:0]  wa;
    int          delay;
    logic [31:0] resp;
    logic        exp_bus;
    logic [3:0]  exp_strobe;
    logic        exp_chk_data;
    logic [31:0] exp_data;
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [31:0] addr, input logic [31:0] sd, input logic rd, input logic wr,
    input logic [1:0] size, input logic uns, input logic m2r, input logic rw,
    input logic [4:0] wa, input int delay, input logic [31:0] resp,
    input logic exp_bus, input logic [3:0] exp_strobe, input logic exp_chk_data,
    input logic [31:0] exp_data, input logic [31:0] exp_rd, input logic exp_mis,
    input logic exp_rw);
    vec_t v;
    v.addr = addr; v.sd = sd; v.rd = rd; v.wr = wr; v.size = size; v.uns = uns;
    v.m2r = m2r; v.rw = rw; v.wa = wa; v.delay = delay; v.resp = resp;
    v.exp_bus = exp_bus; v.exp_strobe = exp_strobe; v.exp_chk_data = exp_chk_data;
    v.exp_data = exp_data; v.exp_rd = exp_rd; v.exp_mis = exp_mis; v.exp_rw = exp_rw;
    return v;
  endfunction

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic drive_op(input logic [31:0] addr, input logic [31:0] sd, input logic rd,
                          input logic wr, input logic [1:0] size, input logic uns,
                          input logic m2r, input logic rw, input logic [4:0] wa);
    ex_valid = 1'b1;
    ex_alu_result = addr; ex_store_data = sd; ex_mem_read = rd; ex_mem_write = wr;
    ex_mem_size = size; ex_mem_unsigned = uns; ex_mem_to_reg = m2r;
    ex_reg_write = rw; ex_regfile_wa = wa;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    check({p, "_ready_before"}, 32'(mem_ready), 32'd1);
    drive_op(v.addr, v.sd, v.rd, v.wr, v.size, v.uns, v.m2r, v.rw, v.wa);
    @(negedge clk);
    idle_ex();
    if (v.exp_bus) begin
      for (int d = 0; d <= v.delay; d++) begin
        check({p, "_dreq_valid"}, 32'(dreq_valid), 32'd1);
        check({p, "_ready_busy"}, 32'(mem_ready), 32'd0);
        check({p, "_dreq_addr"}, dreq_addr, v.addr);
        check({p, "_dreq_strobe"}, 32'(dreq_strobe), 32'(v.exp_strobe));
        if (v.exp_chk_data) check({p, "_dreq_data"}, dreq_data, v.exp_data);
        check({p, "_no_early_wb"}, 32'(wb_valid), 32'd0);
        if (d == v.delay) begin
          dresp_data_ok = 1'b1;
          dresp_data = v.resp;
        end
        @(negedge clk);
      end
      dresp_data_ok = 1'b0;
      dresp_data = 32'hDEAD_0000;
    end else begin
      check({p, "_no_req"}, 32'(dreq_valid), 32'd0);
    end
    exp_q.push_back(v.exp_rd);
    check({p, "_wb_valid"}, 32'(wb_valid), 32'd1);
    check({p, "_wb_read_data"}, wb_read_data, exp_q.pop_front());
    check({p, "_wb_alu_result"}, wb_alu_result, v.addr);
    check({p, "_wb_misalign"}, 32'(wb_misalign), 32'(v.exp_mis));
    check({p, "_wb_reg_write"}, 32'(wb_reg_write), 32'(v.exp_rw));
    check({p, "_wb_wa"}, 32'(wb_regfile_wa), 32'(v.wa));
    check({p, "_wb_m2r"}, 32'(wb_mem_to_reg), 32'(v.m2r));
    check({p, "_dreq_idle"}, 32'(dreq_valid), 32'd0);
    check({p, "_ready_after"}, 32'(mem_ready), 32'd1);
    @(negedge clk);
    check({p, "_wb_pulse_end"}, 32'(wb_valid), 32'd0);
    check({p, "_mis_pulse_end"}, 32'(wb_misalign), 32'd0);
  endtask

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  initial begin
    // Fields: addr, sd, rd, wr, size, uns, m2r, rw, wa, delay, resp,
    //         exp_bus, exp_strobe, exp_chk_data, exp_data, exp_rd, exp_mis, exp_rw
    vecs.push_back(mk(32'h12345678, 32'h0, 0, 0, 2'b10, 0, 0, 1, 5'd5, 0, 32'h0,
                      0, 4'b0000, 0, 32'h0, 32'h0, 0, 1));                       // ALU
    vecs.push_back(mk(32'h00001003, 32'h0, 1, 0, 2'b00, 0, 1, 1, 5'd6, 3, 32'h80FF7F01,
                      1, 4'b0000, 0, 32'h0, 32'hFFFFFF80, 0, 1));                // lb
    vecs.push_back(mk(32'h00001003, 32'h0, 1, 0, 2'b00, 1, 1, 1, 5'd7, 3, 32'h80FF7F01,
                      1, 4'b0000, 0, 32'h0, 32'h00000080, 0, 1));                // lbu
    vecs.push_back(mk(32'h00002002, 32'hAAAABEEF, 0, 1, 2'b01, 0, 0, 0, 5'd0, 0, 32'h0,
                      1, 4'b1100, 1, 32'hBEEFBEEF, 32'h0, 0, 0));                // sh
    vecs.push_back(mk(32'h00003001, 32'h0, 1, 0, 2'b10, 0, 1, 1, 5'd8, 0, 32'h0,
                      0, 4'b0000, 0, 32'h0, 32'h0, 1, 0));                       // lw misaligned
    vecs.push_back(mk(32'h00001002, 32'h0, 1, 0, 2'b01, 0, 1, 1, 5'd9, 1, 32'h80FF7F01,
                      1, 4'b0000, 0, 32'h0, 32'hFFFF80FF, 0, 1));                // lh upper
    vecs.push_back(mk(32'h00001000, 32'h0, 1, 0, 2'b01, 1, 1, 1, 5'd10, 0, 32'h80FF7F01,
                      1, 4'b0000, 0, 32'h0, 32'h00007F01, 0, 1));                // lhu lower
    vecs.push_back(mk(32'h00001001, 32'h0, 1, 0, 2'b00, 0, 1, 1, 5'd11, 2, 32'h80FF7F01,
                      1, 4'b0000, 0, 32'h0, 32'h0000007F, 0, 1));                // lb positive
    vecs.push_back(mk(32'h00000001, 32'h123456A5, 0, 1, 2'b00, 0, 0, 0, 5'd0, 1, 32'h0,
                      1, 4'b0010, 1, 32'hA5A5A5A5, 32'h0, 0, 0));                // sb
    vecs.push_back(mk(32'h00000004, 32'hDEADBEEF, 0, 1, 2'b10, 0, 0, 0, 5'd0, 2, 32'h0,
                      1, 4'b1111, 1, 32'hDEADBEEF, 32'h0, 0, 0));                // sw
    vecs.push_back(mk(32'h00000003, 32'h0, 1, 0, 2'b01, 0, 1, 1, 5'd12, 0, 32'h0,
                      0, 4'b0000, 0, 32'h0, 32'h0, 1, 0));                       // lh misaligned
    vecs.push_back(mk(32'h00000008, 32'h0, 1, 0, 2'b10, 0, 1, 1, 5'd13, 1, 32'hCAFEF00D,
                      1, 4'b0000, 0, 32'h0, 32'hCAFEF00D, 0, 1));                // lw
    vecs.push_back(mk(32'h00000010, 32'h01020304, 1, 1, 2'b10, 0, 0, 0, 5'd0, 0, 32'h55555555,
                      1, 4'b1111, 1, 32'h01020304, 32'h0, 0, 0));                // rd+wr -> store
    vecs.push_back(mk(32'h00000020, 32'h0BADF00D, 0, 1, 2'b11, 0, 0, 0, 5'd0, 0, 32'h0,
                      1, 4'b1111, 1, 32'h0BADF00D, 32'h0, 0, 0));                // size 11 as word
    vecs.push_back(mk(32'h00000022, 32'h0, 1, 0, 2'b11, 0, 1, 1, 5'd14, 0, 32'h0,
                      0, 4'b0000, 0, 32'h0, 32'h0, 1, 0));                       // size 11 misaligned

    // Reset held for two edges; everything must read zero.
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_dreq_valid", 32'(dreq_valid), 32'd0);
    check("rst_dreq_addr", dreq_addr, 32'h0);
    check("rst_dreq_strobe", 32'(dreq_strobe), 32'd0);
    check("rst_dreq_data", dreq_data, 32'h0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_alu", wb_alu_result, 32'h0);
    check("rst_wb_rd", wb_read_data, 32'h0);
    check("rst_wb_flags", {27'd0, wb_mem_to_reg, wb_reg_write, wb_misalign, 2'b00}, 32'd0);
    check("rst_wb_wa", 32'(wb_regfile_wa), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Misaligned lw immediately followed by an ALU op.
    @(negedge clk);
    drive_op(32'h00003001, 32'h0, 1, 0, 2'b10, 0, 1, 1, 5'd3);
    @(negedge clk);
    check("mis_seq_wb_valid", 32'(wb_valid), 32'd1);
    check("mis_seq_misalign", 32'(wb_misalign), 32'd1);
    check("mis_seq_rw", 32'(wb_reg_write), 32'd0);
    check("mis_seq_no_req", 32'(dreq_valid), 32'd0);
    check("mis_seq_ready", 32'(mem_ready), 32'd1);
    drive_op(32'h0000ABCD, 32'h0, 0, 0, 2'b10, 0, 0, 1, 5'd4);
    @(negedge clk);
    idle_ex();
    check("mis_seq_alu_valid", 32'(wb_valid), 32'd1);
    check("mis_seq_alu_mis", 32'(wb_misalign), 32'd0);
    check("mis_seq_alu_res", wb_alu_result, 32'h0000ABCD);
    check("mis_seq_alu_rw", 32'(wb_reg_write), 32'd1);

    // Reset while a store waits for data_ok; a late data_ok is ignored.
    @(negedge clk);
    drive_op(32'h00000040, 32'h11223344, 0, 1, 2'b10, 0, 0, 0, 5'd0);
    @(negedge clk);
    idle_ex();
    check("abort_req_up", 32'(dreq_valid), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_req_down", 32'(dreq_valid), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    check("abort_ready_in_rst", 32'(mem_ready), 32'd0);
    check("abort_no_wb", 32'(wb_valid), 32'd0);
    reset = 1'b1;
    dresp_data_ok = 1'b1;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    check("late_ok_no_wb", 32'(wb_valid), 32'd0);
    check("late_ok_ready", 32'(mem_ready), 32'd1);
    check("late_ok_no_req", 32'(dreq_valid), 32'd0);
    @(negedge clk);
    check("late_ok_no_wb2", 32'(wb_valid), 32'd0);
    check("late_ok_state", 32'(dbg_state), 32'd0);

    // Stream of four ALU ops with ex_valid held high.
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stream_ready%0d", i), 32'(mem_ready), 32'd1);
      drive_op(32'hA0000000 + 32'(i), 32'h0, 0, 0, 2'b10, 0, 0, 1, 5'(16 + i));
      @(negedge clk);
      check($sformatf("stream_wb_valid%0d", i), 32'(wb_valid), 32'd1);
      check($sformatf("stream_wb_alu%0d", i), wb_alu_result, 32'hA0000000 + 32'(i));
      check($sformatf("stream_wb_wa%0d", i), 32'(wb_regfile_wa), 32'(16 + i));
    end
    idle_ex();
    @(negedge clk);
    check("stream_end", 32'(wb_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the MIPS five-stage pipeline, between execute and writeback. Accepts one instruction at a time from execute and performs load/store transactions on the data bus with a request/data_ok handshake. Store data is aligned to byte lanes and loaded data is sign- or zero-extended. It produces the registered alu_result, read_data, mem_to_reg, reg_write and regfile_wa bundle consumed by writeback.

## Interface
- No parameters; data path fixed at 32 bits, 5-bit register addresses.
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- ex_valid  in  1  execute presents an instruction
- mem_ready  out  1  stage can accept; transfer when ex_valid & mem_ready
- ex_alu_result  in  32  ALU result / effective address
- ex_store_data  in  32  rt value for stores
- ex_mem_read, ex_mem_write  in  1 each  load / store
- ex_mem_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- ex_mem_unsigned  in  1  zero-extend loads (lbu/lhu)
- ex_mem_to_reg, ex_reg_write  in  1 each  passed to writeback
- ex_regfile_wa  in  5  destination register
- dreq_valid  out  1  data bus request
- dreq_addr  out  32  byte address
- dreq_strobe  out  4  byte write enables; 0000 for loads
- dreq_data  out  32  lane-aligned store data
- dresp_data_ok  in  1  bus completes the outstanding request
- dresp_data  in  32  raw 32-bit word for loads
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_alu_result, wb_read_data  out  32 each  to writeback
- wb_mem_to_reg, wb_reg_write  out  1 each  to writeback
- wb_regfile_wa  out  5  to writeback
- wb_misalign  out  1  address-error flag for this instruction

## Operation
- States: IDLE, BUSY. mem_ready = reset & (state == IDLE).
- IDLE, handshake fires, non-memory op: next edge loads the wb_* register and asserts wb_valid=1 with wb_read_data=0. State stays IDLE.
- IDLE, handshake fires, memory op, aligned: latch all ex_* fields and go to BUSY. Nothing is written to wb_* yet.
- Misaligned means half with addr[0]=1, or word with addr[1:0]≠00. No bus request is made. Next edge: wb_valid=1, wb_misalign=1, wb_reg_write=0, wb_read_data=0, wb_alu_result=address. State stays IDLE.
- BUSY: dreq_valid=1, driven from latched fields, and held stable until dresp_data_ok.
- On dresp_data_ok in BUSY: next edge loads wb_* (wb_read_data = extended load, or 0 for stores), wb_valid=1, state goes to IDLE.
- ex_mem_read and ex_mem_write both set: treated as a store.
- Store lanes, with o = addr[1:0]:
  - byte: data {4{sd[7:0]}}, strobe 0001<<o
  - half: data {2{sd[15:0]}}, strobe 0011<<o
  - word: data sd, strobe 1111
- Load extraction: the byte is dresp_data[8o+7:8o]; the half is dresp_data[16·o[1]+15:16·o[1]]. Each is sign-extended, or zero-extended if unsigned. Word loads pass through unchanged.
- wb_valid and wb_misalign are 0 in every cycle without a retirement. wb_* data fields hold their last values.
- dresp_data_ok in IDLE is ignored.

## Timing
- Reset (reset=0 at an edge): state=IDLE; dreq_valid=0, dreq_strobe=0, dreq_addr=0, dreq_data=0; all wb_* = 0. mem_ready=0 while reset=0.
- Reset mid-transaction: the request is abandoned, dreq_valid=0 from the next cycle, and no wb_valid is produced for it.
- Non-memory or misaligned op: accepted at edge N, wb_valid high in cycle N+1. Back-to-back throughput is 1 per cycle.
- Memory op accepted at edge N:
  - dreq_valid first high in cycle N+1.
  - If dresp_data_ok is seen in cycle K (K ≥ N+1, same-cycle completion allowed), wb_valid is high in cycle K+1.
  - mem_ready is 0 from cycle N+1 through K, and 1 again in cycle K+1.
  - Minimum load/store latency is 2 cycles; a new instruction may be accepted in cycle K+1.
- dreq_addr, dreq_strobe and dreq_data must not change while dreq_valid=1 and data_ok has not arrived.
- Downstream (writeback) never stalls; wb_* is a plain register.

## Test plan
- Reset held 2 cycles, then ALU op ex_alu_result=0x12345678, wa=5, reg_write=1 -> wb_valid pulse next cycle, wb_alu_result=0x12345678, wb_mem_to_reg=0, all outputs 0 during reset.
- lb at addr 0x1003, dresp_data=0x80FF7F01 after 3-cycle bus delay -> dreq_strobe=0000, dreq_addr=0x1003; wb_read_data=0xFFFFFF80 one cycle after data_ok. With lbu -> 0x00000080. mem_ready=0 throughout.
- sh at 0x2002, store_data=0xAAAABEEF, data_ok same cycle as first dreq_valid -> dreq_strobe=1100, dreq_data=0xBEEFBEEF; wb_valid exactly 2 cycles after acceptance, wb_read_data=0.
- lw at 0x3001 -> no dreq_valid; next cycle wb_valid=1, wb_misalign=1, wb_reg_write=0. A following ALU op is accepted the next cycle.
- Store in BUSY with no data_ok, reset=0 for one cycle -> dreq_valid=0 and state IDLE afterwards; a late data_ok is ignored and no wb_valid is produced.
- Stream of 4 ALU ops with ex_valid continuously high -> 4 consecutive wb_valid pulses and mem_ready stays 1.
